// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//
// Exhaustive truth-table checker for an N_IN-input single-output logic gate.
// A start request sweeps every input combination 0 .. 2^N_IN-1 onto dut_in.
// Each vector is held for SETTLE+2 cycles, and dut_y is then compared against
// the reference function chosen by mode (latched when the sweep starts).
// Mismatches are counted with saturation, and the first failing vector is kept.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            one-cycle sweep request, honoured only when idle or done
//   mode[2:0]        0 NOR, 1 OR, 2 NAND, 3 AND, 4 XOR, 5 XNOR, 6 INV(in[0]), 7 BUF(in[0])
//   dut_y            DUT output, sampled directly (same clock domain)
//   dut_in[N_IN-1:0] vector driven to the DUT, MSB is the first operand
//   busy             sweep in progress
//   done             sweep finished, held until the next accepted start or rst
//   pass             done with zero mismatches
//   err_cnt          saturating mismatch count
//   first_fail_vec   first mismatching vector
//   first_fail_valid first_fail_vec holds a captured value
module gate_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              dut_y,
    output logic [N_IN-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
    // Vector counter is one bit wider than dut_in, so the last vector is
    // recognised explicitly and the counter never wraps to 0 mid-sweep.
    localparam logic [N_IN:0]    LAST_VEC = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0]    VEC_ONE  = {{N_IN{1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    // Odd parity of the full input vector (XOR reduction).
    function automatic logic odd_parity(input logic [N_IN-1:0] v);
        return ^v;
    endfunction

    // Reference output of the selected gate for input vector v.
    function automatic logic ref_fn(input logic [2:0] m, input logic [N_IN-1:0] v);
        logic r;
        case (m)
            3'd0:    r = ~(|v);
            3'd1:    r = |v;
            3'd2:    r = ~(&v);
            3'd3:    r = &v;
            3'd4:    r = odd_parity(v);
            3'd5:    r = ~odd_parity(v);
            3'd6:    r = ~v[0];
            3'd7:    r = v[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Counter increment that sticks at the all-ones maximum.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == ERR_MAX) ? c : (c + ERR_ONE);
    endfunction

    state_t             state_r;
    logic [N_IN:0]      vec_r;
    logic [3:0]         hold_r;
    logic [2:0]         mode_r;
    logic [N_IN-1:0]    dut_in_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [ERR_W-1:0]   err_r;
    logic [N_IN-1:0]    ff_vec_r;
    logic               ff_valid_r;

    logic               ref_s;
    logic               mismatch_s;
    logic [ERR_W-1:0]   err_next_s;
    logic               last_s;
    logic [N_IN:0]      vec_inc_s;

    // Comparison of the current sample against the reference and next-count logic.
    always_comb begin
        ref_s      = ref_fn(mode_r, vec_r[N_IN-1:0]);
        mismatch_s = (dut_y != ref_s);
        last_s     = (vec_r == LAST_VEC);
        vec_inc_s  = vec_r + VEC_ONE;
        if (mismatch_s) begin
            err_next_s = sat_inc(err_r);
        end else begin
            err_next_s = err_r;
        end
    end

    // Sweep state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            vec_r      <= '0;
            hold_r     <= 4'd0;
            mode_r     <= 3'd0;
            dut_in_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= '0;
            ff_vec_r   <= '0;
            ff_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_r     <= mode;
                        vec_r      <= '0;
                        dut_in_r   <= '0;
                        hold_r     <= SETTLE_C;
                        err_r      <= '0;
                        ff_vec_r   <= '0;
                        ff_valid_r <= 1'b0;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Counter reaching zero ends the settle window; with SETTLE=0
                    // this state therefore lasts exactly one cycle.
                    if (hold_r == 4'd0) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        hold_r <= hold_r - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    err_r <= err_next_s;
                    if (mismatch_s && !ff_valid_r) begin
                        ff_vec_r   <= vec_r[N_IN-1:0];
                        ff_valid_r <= 1'b1;
                    end
                    if (last_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == '0);
                        state_r <= ST_DONE;
                    end else begin
                        vec_r    <= vec_inc_s;
                        dut_in_r <= vec_inc_s[N_IN-1:0];
                        hold_r   <= SETTLE_C;
                        state_r  <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in           = dut_in_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_cnt          = err_r;
    assign first_fail_vec   = ff_vec_r;
    assign first_fail_valid = ff_valid_r;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker.
// Instance A: N_IN=2, SETTLE=1, ERR_W=8, driven by a behavioural gate model.
// Instance B: N_IN=3, ERR_W=2, fed with an inverted AND so that the error counter saturates.
module tb_gate_sweep_checker;

    localparam int SETTLE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [2:0] mode_a, mode_b;
    logic       y_a, y_b;
    logic [1:0] in_a;
    logic [2:0] in_b;
    logic       busy_a, done_a, pass_a, ffvalid_a;
    logic       busy_b, done_b, pass_b, ffvalid_b;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic [1:0] ffv_a;
    logic [2:0] ffv_b;

    int fault_a = 0;   // 0: ideal NOR gate, 1: output stuck at 0
    int tests   = 0;
    int fails   = 0;

    typedef struct packed {
        logic [7:0] err;
        logic       pass;
        logic       ffvalid;
        logic [1:0] ffvec;
    } exp_t;
    exp_t sb_q[$];

    gate_sweep_checker #(.N_IN(2), .SETTLE(SETTLE), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .dut_y(y_a),
        .dut_in(in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_fail_vec(ffv_a), .first_fail_valid(ffvalid_a)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(SETTLE), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .dut_y(y_b),
        .dut_in(in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_fail_vec(ffv_b), .first_fail_valid(ffvalid_b)
    );

    // Gate under test for instance A.
    always_comb begin
        y_a = 1'b0;
        if (fault_a == 0) y_a = (in_a == 2'b00);
    end
    assign y_b = ~(in_b == 3'b111);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference gate output, written independently via the count of ones.
    function automatic logic tb_ref(input logic [2:0] m, input int v, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (m)
            3'd0: return ones == 0;
            3'd1: return ones != 0;
            3'd2: return ones != n;
            3'd3: return ones == n;
            3'd4: return (ones % 2) == 1;
            3'd5: return (ones % 2) == 0;
            3'd6: return (v & 1) == 0;
            default: return (v & 1) == 1;
        endcase
    endfunction

    // Full sweep on instance A; optionally pokes start while busy.
    task automatic run_sweep(input logic [2:0] m, input int fault, input bit poke_busy);
        exp_t e;
        logic y;
        exp_t got;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            y = (fault == 0) ? (v == 0) : 1'b0;
            if (y != tb_ref(m, v, 2)) begin
                if (e.err != 8'hFF) e.err++;
                if (!e.ffvalid) begin
                    e.ffvalid = 1'b1;
                    e.ffvec   = 2'(v);
                end
            end
        end
        e.pass = (e.err == 8'd0);
        sb_q.push_back(e);

        fault_a = fault;
        mode_a  = m;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        mode_a  = ~m;   // must have no effect on the running sweep
        check("accept_done_clr", done_a, 0);
        check("accept_pass_clr", pass_a, 0);
        check("accept_err_clr", err_a, 0);
        check("accept_ffvalid_clr", ffvalid_a, 0);
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < SETTLE + 2; c++) begin
                check("vec_hold", in_a, v);
                check("busy_hold", busy_a, 1);
                if (poke_busy && v == 1 && c == 0) start_a = 1'b1;
                @(posedge clk); #1;
                start_a = 1'b0;
            end
        end
        check("done_set", done_a, 1);
        check("busy_clr", busy_a, 0);
        got = sb_q.pop_front();
        check("err_cnt", err_a, got.err);
        check("pass", pass_a, got.pass);
        check("ffvalid", ffvalid_a, got.ffvalid);
        check("ffvec", ffv_a, got.ffvec);
        @(posedge clk); #1;
        check("done_held", done_a, 1);
        check("last_vec_held", in_a, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        mode_a = 3'd0; mode_b = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dut_in", in_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_ffvalid", ffvalid_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // NOR gate against NOR, stuck-at-0, then against XOR.
        run_sweep(3'd0, 0, 1'b0);
        run_sweep(3'd0, 1, 1'b0);
        run_sweep(3'd4, 0, 1'b0);
        // Start while busy is ignored; start directly from DONE restarts cleanly.
        run_sweep(3'd1, 0, 1'b1);
        run_sweep(3'd7, 0, 1'b0);

        // Reset in the middle of vector 10.
        fault_a = 0; mode_a = 3'd0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (in_a != 2'b10 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_vec10", in_a, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_dut_in", in_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_err", err_a, 0);
        check("mid_rst_ffvalid", ffvalid_a, 0);
        check("mid_rst_ffvec", ffv_a, 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", busy_a, 0);
        run_sweep(3'd0, 0, 1'b0);

        // Saturating counter on the 3-input instance.
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        mode_b  = 3'd0;
        n = 0;
        while (!done_b && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_sweep_len", n, 8 * (SETTLE + 2));
        check("b_err_sat", err_b, 3);
        check("b_ffvalid", ffvalid_b, 1);
        check("b_ffvec", ffv_b, 0);
        check("b_pass", pass_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Synthesizable, parametrised exhaustive truth-table checker for N-input logic gates (switch-level or gate-level DUTs). On start it sweeps every input combination into the DUT and holds each one for a settle window. It then samples the DUT output, compares it against a mode-selected reference function, and reports an error count, the first failing vector and a pass/fail flag. It replaces hand-written stimulus loops and sits beside the DUT in self-checking benches and on-chip BIST wrappers.

Parameters:
N_IN, 2, DUT input count (1..8); sweep length is 2^N_IN vectors.
SETTLE, 1, extra cycles each vector is held before sampling (0..15).
ERR_W, 8, width of the mismatch counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle request to begin a sweep.
mode  input  3  reference function: 0 NOR, 1 OR, 2 NAND, 3 AND, 4 XOR (odd parity), 5 XNOR, 6 INV(in[0]), 7 BUF(in[0]).
dut_y  input  1  DUT output.
dut_in  output  N_IN  vector driven to DUT; bit N_IN-1 is MSB (first operand).
busy  output  1  sweep in progress.
done  output  1  sweep complete; level, held until next accepted start or rst.
pass  output  1  done && err_cnt==0.
err_cnt  output  ERR_W  mismatch count, saturating.
first_fail_vec  output  N_IN  first mismatching vector.
first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (rst=1 at edge): state IDLE; dut_in, busy, done, pass, err_cnt, first_fail_vec and first_fail_valid all 0. Applies mid-sweep; the sweep is abandoned with no partial results.
- FSM states IDLE, HOLD, SAMPLE, DONE.
- Start acceptance: start is accepted only in IDLE or DONE. At acceptance: latch mode; vec=0; dut_in=0; hold counter=SETTLE; clear err_cnt, first_fail_*, done and pass; busy=1; next state HOLD.
- start while busy is ignored. Changing mode mid-sweep has no effect.
- HOLD: decrement the hold counter each cycle. When it is 0, go to SAMPLE. With SETTLE=0, HOLD lasts exactly one cycle.
- SAMPLE (one cycle): compare dut_y against ref(mode, vec).
  - On mismatch: err_cnt+1, saturating at 2^ERR_W-1. If first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec is not the last (2^N_IN-1): vec+1, dut_in updates at this same edge, counter=SETTLE, next state HOLD.
  - If vec is the last: next state DONE, busy=0, done=1, pass=(final err_cnt==0). The final err_cnt includes this sample.
- Each vector is driven for SETTLE+2 cycles. A sweep spans 2^N_IN*(SETTLE+2) cycles from the start-accept edge to the done edge.
- DONE: dut_in holds the last vector; all results are held. An accepted start leaves via the start-acceptance rules (done clears at that edge).
- Reference functions use all N_IN bits, except INV/BUF, which use bit 0 only.
- The counter vec is N_IN+1 bits internally; there is no wrap-around to 0 within a sweep.
- Outputs are registered. dut_y is sampled directly and is not synchronised (same clock domain).

Test Plan:
1. N_IN=2, SETTLE=1, mode=0, ideal NOR DUT -> dut_in steps 00,01,10,11, each held 3 cycles; done=1 12 cycles after start-accept; err_cnt=0, pass=1, first_fail_valid=0.
2. mode=0, dut_y stuck at 0 -> only vector 00 mismatches; err_cnt=1, first_fail_vec=00, first_fail_valid=1, pass=0.
3. mode=4 (XOR) with ideal NOR DUT -> mismatches at 00, 01, 10; err_cnt=3, first_fail_vec=00, pass=0.
4. N_IN=3, ERR_W=2, mode=3, DUT outputs ~AND -> 8 mismatches; err_cnt saturates at 3, first_fail_vec=000.
5. rst asserted during vector 10 of a 2-input sweep -> next cycle all outputs 0 and state IDLE. A new start then gives a full clean sweep (err_cnt=0, pass=1 with an ideal DUT).
6. start pulsed while busy -> ignored, sweep length unchanged. start pulsed while done=1 -> done and pass clear at that edge and a fresh sweep begins from dut_in=00.
